sim_mem_responder: RTL

// - Synthesizable multi-lane memory responder; the target end of the SimMem A/D request/response interface.
// - Accepts per-lane A-channel load/store requests and returns per-lane D-channel responses after a fixed latency.
// - Backed by a shared word-addressed register-array memory; used as the DUT-side memory model for the memory fuzzer.

---
 rtl/sim_mem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sim_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sim_mem_responder
// Desc     : Multi-lane SimMem A/D memory target; in-order fixed-latency
//            responses from a shared word memory. Optional macro
//            SIMMEM_BACKPRESSURE_EN throttles a_ready with per-lane LFSRs.
// Revision : 1.0
// ============================================================================
module sim_mem_responder #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 3,
  parameter int MEM_WORDS     = 256,
  parameter int QUEUE_DEPTH   = 4,
  parameter int LATENCY       = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LANES-1:0]               a_valid,
  output logic [NUM_LANES-1:0]               a_ready,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
  input  logic [NUM_LANES-1:0]               a_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
  output logic [NUM_LANES-1:0]               d_valid,
  input  logic [NUM_LANES-1:0]               d_ready,
  output logic [NUM_LANES-1:0]               d_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
  output logic                               inflight
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_OFF   = $clog2(c_BYTES);
  localparam int c_IDXW  = $clog2(MEM_WORDS);
  localparam int c_QAW   = $clog2(QUEUE_DEPTH);
  localparam int c_CNTW  = c_QAW + 1;
  localparam int c_AGEW  = 4;
  localparam logic [c_AGEW-1:0] c_LAT  = c_AGEW'(LATENCY);
  localparam logic [c_CNTW-1:0] c_FULL = c_CNTW'(QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0]    r_mem     [MEM_WORDS];
  logic                     r_q_store [NUM_LANES][QUEUE_DEPTH];
  logic [LOGSIZE_WIDTH-1:0] r_q_size  [NUM_LANES][QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]    r_q_data  [NUM_LANES][QUEUE_DEPTH];
  logic [c_AGEW-1:0]        r_q_age   [NUM_LANES][QUEUE_DEPTH];
  logic [c_QAW-1:0]         r_wptr    [NUM_LANES];
  logic [c_QAW-1:0]         r_rptr    [NUM_LANES];
  logic [c_CNTW-1:0]        r_cnt     [NUM_LANES];

  logic [NUM_LANES-1:0]     w_full;
  logic [NUM_LANES-1:0]     w_nonempty;
  logic [NUM_LANES-1:0]     w_a_fire;
  logic [NUM_LANES-1:0]     w_d_fire;
  logic [NUM_LANES-1:0]     w_lfsr_ok;
  logic [c_IDXW-1:0]        w_idx     [NUM_LANES];
  logic [c_BYTES-1:0]       w_mask    [NUM_LANES];
  logic [DATA_WIDTH-1:0]    w_wdata   [NUM_LANES];
  logic                     w_unused;

  // Address bits above the word index alias onto the same storage.
  assign w_unused = ^a_address;

  function automatic int access_bytes(input logic [LOGSIZE_WIDTH-1:0] size);
    int s;
    s = int'(size);
    if (s > c_OFF) s = c_OFF;
    return 1 << s;
  endfunction

  always_comb begin
    int n;
    int off;
    n   = 0;
    off = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      n          = access_bytes(a_size[LOGSIZE_WIDTH*l +: LOGSIZE_WIDTH]);
      off        = int'(a_address[DATA_WIDTH*l +: c_OFF]) & ~(n - 1);
      w_idx[l]   = a_address[DATA_WIDTH*l + c_OFF +: c_IDXW];
      w_wdata[l] = a_data[DATA_WIDTH*l +: DATA_WIDTH] << (8 * off);
      for (int k = 0; k < c_BYTES; k++) begin
        w_mask[l][k] = (k >= off) && (k < off + n);
      end
    end
  end

`ifdef SIMMEM_BACKPRESSURE_EN
  logic [15:0] r_lfsr [NUM_LANES];

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  always_ff @(posedge clock) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (reset) begin
        r_lfsr[l] <= 16'hACE1 ^ 16'(l);
      end else begin
        r_lfsr[l] <= {r_lfsr[l][0] ^ r_lfsr[l][2] ^ r_lfsr[l][3] ^ r_lfsr[l][5],
                      r_lfsr[l][15:1]};
      end
    end
  end

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_bp
      assign w_lfsr_ok[l] = r_lfsr[l][0];
    end
  endgenerate
`else
  assign w_lfsr_ok = '1;
`endif

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [c_QAW-1:0] w_head;
      assign w_head        = r_rptr[l];
      assign w_full[l]     = (r_cnt[l] == c_FULL);
      assign w_nonempty[l] = (r_cnt[l] != '0);
      assign a_ready[l]    = ~reset & ~w_full[l] & w_lfsr_ok[l];
      assign d_valid[l]    = ~reset & w_nonempty[l] & (r_q_age[l][w_head] == c_LAT);
      assign w_a_fire[l]   = a_valid[l] & a_ready[l];
      assign w_d_fire[l]   = d_valid[l] & d_ready[l];
      assign d_is_store[l] = d_valid[l] & r_q_store[l][w_head];
      assign d_size[LOGSIZE_WIDTH*l +: LOGSIZE_WIDTH] =
        d_valid[l] ? r_q_size[l][w_head] : '0;
      assign d_data[DATA_WIDTH*l +: DATA_WIDTH] =
        d_valid[l] ? r_q_data[l][w_head] : '0;
    end
  endgenerate

  assign inflight = ~reset & (|w_nonempty);

  // Ascending lane order: the highest lane's write to a byte lands last.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_a_fire[l] && a_is_store[l]) begin
          for (int k = 0; k < c_BYTES; k++) begin
            if (w_mask[l][k]) r_mem[w_idx[l]][8*k +: 8] <= w_wdata[l][8*k +: 8];
          end
        end
      end
    end
  end

  // Loads capture the pre-write word, so same-cycle stores are not visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_wptr[l] <= '0;
        r_rptr[l] <= '0;
        r_cnt[l]  <= '0;
        for (int e = 0; e < QUEUE_DEPTH; e++) begin
          r_q_store[l][e] <= 1'b0;
          r_q_size[l][e]  <= '0;
          r_q_data[l][e]  <= '0;
          r_q_age[l][e]   <= '0;
        end
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int e = 0; e < QUEUE_DEPTH; e++) begin
          if (r_q_age[l][e] != c_LAT) r_q_age[l][e] <= r_q_age[l][e] + 1'b1;
        end
        if (w_a_fire[l]) begin
          r_q_store[l][r_wptr[l]] <= a_is_store[l];
          r_q_size[l][r_wptr[l]]  <= a_size[LOGSIZE_WIDTH*l +: LOGSIZE_WIDTH];
          r_q_data[l][r_wptr[l]]  <= a_is_store[l] ? '0 : r_mem[w_idx[l]];
          r_q_age[l][r_wptr[l]]   <= c_AGEW'(1);
          r_wptr[l]               <= r_wptr[l] + 1'b1;
        end
        if (w_d_fire[l]) r_rptr[l] <= r_rptr[l] + 1'b1;
        case ({w_a_fire[l], w_d_fire[l]})
          2'b10:   r_cnt[l] <= r_cnt[l] + 1'b1;
          2'b01:   r_cnt[l] <= r_cnt[l] - 1'b1;
          default: r_cnt[l] <= r_cnt[l];
        endcase
      end
    end
  end

endmodule
`default_nettype wire
